// File: rtl/output_channel_controller_pkg.sv
// Shared definitions for the router output channel controller: channel count,
// one-hot port constants, FSM state encoding and the grant priority helper.
package output_channel_controller_pkg;

  localparam int CHANNELS           = 5;
  localparam int DEFAULT_FLIT_WIDTH = 34;
  localparam int CREDIT_WIDTH       = 4;

  localparam logic [CHANNELS-1:0] P0 = 5'b00001;
  localparam logic [CHANNELS-1:0] P1 = 5'b00010;
  localparam logic [CHANNELS-1:0] P2 = 5'b00100;
  localparam logic [CHANNELS-1:0] P3 = 5'b01000;
  localparam logic [CHANNELS-1:0] P4 = 5'b10000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // A malformed multi-bit grant resolves to its lowest set index.
  function automatic logic [CHANNELS-1:0] lowest_set(input logic [CHANNELS-1:0] v);
    logic [CHANNELS-1:0] r;
    logic                found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/output_channel_controller_credit_counter.sv
// Downstream buffer credit counter: saturates at P_CREDITS, never wraps below
// zero, and flags a sticky error when a credit returns while already full.
module credit_counter
  import output_channel_controller_pkg::*;
#(
  parameter int P_CREDITS = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    inc,
  input  logic                    dec,
  output logic [CREDIT_WIDTH-1:0] count,
  output logic                    nonzero,
  output logic                    err
);

  localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(P_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] ONE  = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] count_q, count_d;
  logic                    err_q, err_d;

  // Simultaneous send and return cancel out, so only lone events move the count.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (dec && !inc) begin
      if (count_q != '0) begin
        count_d = count_q - ONE;
      end
    end else if (inc && !dec) begin
      if (count_q == FULL) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= FULL;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count   = count_q;
  assign nonzero = (count_q != '0);
  assign err     = err_q;

endmodule

// File: rtl/output_channel_controller.sv
// Output channel allocation holder: locks the port to the granted input from
// head to tail, muxes its flits onto a registered output and tracks credits.
module output_channel_controller
  import output_channel_controller_pkg::*;
#(
  parameter int P_ROUTER_ID  = 0,
  parameter int P_CHANNEL_ID = 0,
  parameter int P_CREDITS    = 4,
  parameter int P_FLIT_WIDTH = DEFAULT_FLIT_WIDTH
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [CHANNELS-1:0]              grants,
  output logic [CHANNELS-1:0]              enables,
  input  logic [CHANNELS-1:0]              in_valid,
  input  logic [CHANNELS*P_FLIT_WIDTH-1:0] in_flits,
  input  logic [CHANNELS-1:0]              in_tail,
  output logic [CHANNELS-1:0]              in_ack,
  output logic                             out_valid,
  output logic [P_FLIT_WIDTH-1:0]          out_flit,
  input  logic                             credit_in,
  output logic                             credit_err
);

  if (P_CREDITS < 1 || P_CREDITS > 15) begin : g_bad_credits
    $error("router %0d channel %0d: P_CREDITS must be 1..15", P_ROUTER_ID, P_CHANNEL_ID);
  end

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(P_CREDITS);

  state_e                    state_q, state_d;
  logic [CHANNELS-1:0]       owner_q, owner_d;
  logic                      out_valid_q, out_valid_d;
  logic [P_FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;

  logic [P_FLIT_WIDTH-1:0]   sel_flit;
  logic                      owner_valid;
  logic                      owner_tail;
  logic                      send;
  logic [CREDIT_WIDTH-1:0]   credit_count;
  logic                      credit_nonzero;

  credit_counter #(
    .P_CREDITS (P_CREDITS)
  ) u_credit_counter (
    .CLK     (CLK),
    .RST     (RST),
    .inc     (credit_in),
    .dec     (send),
    .count   (credit_count),
    .nonzero (credit_nonzero),
    .err     (credit_err)
  );

  // owner_q is one-hot or zero, so an OR of masked slices is the crossbar mux.
  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (owner_q[i]) begin
        sel_flit = sel_flit | in_flits[i*P_FLIT_WIDTH +: P_FLIT_WIDTH];
      end
    end
    owner_valid = |(in_valid & owner_q);
    owner_tail  = |(in_tail & owner_q);
    send        = (state_q == ST_BUSY) && owner_valid && credit_nonzero;
    in_ack      = send ? owner_q : '0;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    out_valid_d = send;
    out_flit_d  = send ? sel_flit : out_flit_q;
    case (state_q)
      ST_IDLE: begin
        if (grants != '0) begin
          state_d = ST_BUSY;
          owner_d = lowest_set(grants);
        end
      end
      ST_BUSY: begin
        if (send && owner_tail) begin
          state_d = ST_IDLE;
          owner_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign enables   = owner_q;
  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;

  a_credit_bound: assert property (@(posedge CLK) disable iff (RST) credit_count <= CREDIT_FULL);

endmodule

// File: tb/tb_output_channel_controller.sv
// Scoreboard bench for output_channel_controller: a packet-level reference model
// predicts acks, ownership and credits; a monitor checks every emitted flit.
module tb_output_channel_controller;
  import output_channel_controller_pkg::*;

  localparam int W    = 34;
  localparam int CRED = 4;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [CHANNELS-1:0]   grants, enables, in_valid, in_tail, in_ack;
  logic [CHANNELS*W-1:0] in_flits;
  logic                  out_valid;
  logic [W-1:0]          out_flit;
  logic                  credit_in, credit_err;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_owner   = -1;
  int          m_credits = CRED;
  bit          m_err     = 1'b0;
  logic [W-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  output_channel_controller #(
    .P_ROUTER_ID  (0),
    .P_CHANNEL_ID (0),
    .P_CREDITS    (CRED),
    .P_FLIT_WIDTH (W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .grants     (grants),
    .enables    (enables),
    .in_valid   (in_valid),
    .in_flits   (in_flits),
    .in_tail    (in_tail),
    .in_ack     (in_ack),
    .out_valid  (out_valid),
    .out_flit   (out_flit),
    .credit_in  (credit_in),
    .credit_err (credit_err)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CHANNELS-1:0] onehot(input int idx);
    if (idx < 0) return '0;
    return CHANNELS'(1) << idx;
  endfunction

  // Reference model: one packet owner at a time, credits as a plain integer.
  task automatic modelStep(input bit s);
    int new_owner;
    new_owner = m_owner;
    if (m_owner < 0) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (grants[i]) new_owner = i;
      end
    end else if (s && in_tail[m_owner]) begin
      new_owner = -1;
    end
    if (s) exp_q.push_back(in_flits[m_owner*W +: W]);
    if (s && !credit_in) begin
      m_credits--;
    end else if (credit_in && !s) begin
      if (m_credits == CRED) m_err = 1'b1;
      else m_credits++;
    end
    m_owner = new_owner;
  endtask

  task automatic checkOutput();
    bit s;
    s = (m_owner >= 0) && in_valid[m_owner] && (m_credits > 0);
    cmp("enables", enables, onehot(m_owner));
    cmp("in_ack", in_ack, s ? onehot(m_owner) : '0);
    cmp("credit_err", credit_err, m_err);
    modelStep(s);
  endtask

  task automatic applyStimulus(input logic [CHANNELS-1:0] g, input logic [CHANNELS-1:0] v,
                               input logic [CHANNELS-1:0] t, input logic c);
    @(negedge CLK);
    grants    = g;
    in_valid  = v;
    in_tail   = t;
    credit_in = c;
    for (int i = 0; i < CHANNELS; i++) begin
      in_flits[i*W +: W] = W'({$urandom, $urandom});
    end
    #1;
    checkOutput();
  endtask

  task automatic checkResetOutputs(input string tag);
    cmp({tag, "_enables"}, enables, '0);
    cmp({tag, "_in_ack"}, in_ack, '0);
    cmp({tag, "_out_valid"}, out_valid, '0);
    cmp({tag, "_out_flit"}, out_flit, '0);
    cmp({tag, "_credit_err"}, credit_err, '0);
  endtask

  task automatic doReset();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkResetOutputs("async_rst");
    m_owner   = -1;
    m_credits = CRED;
    m_err     = 1'b0;
    exp_q.delete();
    grants    = '0;
    in_valid  = '0;
    in_tail   = '0;
    credit_in = 1'b0;
    @(negedge CLK);
    #2;
    RST = 1'b0;
  endtask

  // Output monitor: a flit is due exactly one edge after the model saw its ack.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (!RST) begin
        cmp("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          if (out_valid) cmp("out_flit", out_flit, exp_q.pop_front());
          else void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [CHANNELS-1:0] rg, rv, rt;
    int guard;
    grants    = '0;
    in_valid  = '0;
    in_tail   = '0;
    in_flits  = '0;
    credit_in = 1'b0;
    #2;
    checkResetOutputs("reset");
    #10;
    RST = 1'b0;

    applyStimulus(P2, '0, '0, 1'b0);
    applyStimulus('0, P2, P2, 1'b0);
    applyStimulus('0, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, 1'b1);

    applyStimulus(P1, '0, '0, 1'b0);
    repeat (6) applyStimulus('0, P1, '0, 1'b0);
    applyStimulus('0, P1, '0, 1'b1);
    applyStimulus('0, P1, P1, 1'b0);
    repeat (4) applyStimulus('0, '0, '0, 1'b1);

    applyStimulus(P1 | P2, '0, '0, 1'b0);
    applyStimulus(P4, P1 | P4, '0, 1'b0);
    applyStimulus(P4, P1, P1, 1'b1);
    applyStimulus(P3, '0, '0, 1'b0);
    applyStimulus('0, P3, P3, 1'b1);
    applyStimulus('0, '0, '0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      rg = ($urandom_range(1) == 0) ? '0 : CHANNELS'($urandom);
      rv = CHANNELS'($urandom);
      rt = CHANNELS'($urandom) & CHANNELS'($urandom);
      applyStimulus(rg, rv, rt, (m_credits < CRED) && ($urandom_range(1) == 1));
    end

    guard = 0;
    while (m_credits < CRED && guard < 20) begin
      applyStimulus('0, '0, '0, 1'b1);
      guard++;
    end
    cmp("credit_refill", m_credits, CRED);
    applyStimulus('0, '0, '0, 1'b1);
    applyStimulus('0, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, 1'b0);

    applyStimulus(P0, '1, '0, 1'b0);
    applyStimulus('0, '1, '0, 1'b0);
    doReset();
    applyStimulus(P0, '0, '0, 1'b0);
    applyStimulus('0, P0, P0, 1'b0);
    applyStimulus('0, '0, '0, 1'b0);

    @(negedge CLK);
    @(negedge CLK);
    cmp("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
